// File: rtl/draw_pkg.sv
// Shared types and helpers for the rectangle plotter: FSM states, default screen size
// and the border test used in outline mode.
package draw_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} plot_state_t;

  localparam int unsigned DefScreenW = 160;
  localparam int unsigned DefScreenH = 120;

  // Width wide enough for any coordinate field the plotter is built with.
  localparam int unsigned CoordW = 16;

  function automatic logic on_border(input logic [CoordW-1:0] dx, input logic [CoordW-1:0] dy,
                                     input logic [CoordW-1:0] w,  input logic [CoordW-1:0] h);
    return (dx == '0) || (dy == '0) || (dx == w - CoordW'(1)) || (dy == h - CoordW'(1));
  endfunction

endpackage

// File: rtl/rect_plotter_if.sv
// Registered pixel stream towards the VGA sink: position, colour and valid (plot),
// with pixel_ready flowing back from the sink.
interface rect_plotter_if #(
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COLOR_W = 3
) ();

  logic [X_W-1:0]     VGA_X;
  logic [Y_W-1:0]     VGA_Y;
  logic [COLOR_W-1:0] VGA_COLOR;
  logic               plot;
  logic               pixel_ready;

  modport master (output VGA_X, output VGA_Y, output VGA_COLOR, output plot, input pixel_ready);
  modport slave  (input VGA_X, input VGA_Y, input VGA_COLOR, input plot, output pixel_ready);

endinterface

// File: rtl/rect_scan_counter.sv
// Row-major dx/dy offset counter for the rectangle scan. Exposes the next-state offsets so
// the owner can register pixel outputs for the position being entered.
module rect_scan_counter #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           step_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] dx_nxt_o,
  output logic [Y_W-1:0] dy_nxt_o,
  output logic           last_o
);

  logic [X_W-1:0] dx_q, dx_d;
  logic [Y_W-1:0] dy_q, dy_d;
  logic           row_end;

  assign row_end = (dx_q == w_i - X_W'(1));
  assign last_o  = row_end && (dy_q == h_i - Y_W'(1));

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (step_i) begin
      if (row_end) begin
        dx_d = '0;
        dy_d = dy_q + Y_W'(1);
      end else begin
        dx_d = dx_q + X_W'(1);
      end
    end
  end

  assign dx_nxt_o = dx_d;
  assign dy_nxt_o = dy_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Filled/outlined rectangle generator: scans the rectangle row-major after a start pulse
// and emits clipped pixels over a registered valid/ready stream.
module rect_plotter
  import draw_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SCREEN_W = DefScreenW,
  parameter int unsigned SCREEN_H = DefScreenH
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] color,
  input  logic               outline,
  rect_plotter_if.master     pix,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] ScreenWX = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] ScreenHY = (Y_W+1)'(SCREEN_H);

  plot_state_t        state_q, state_d;
  logic [X_W-1:0]     x0_q, x0_d, w_q, w_d;
  logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               outline_q, outline_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_color_q, vga_color_d;
  logic               plot_q, plot_d;

  logic               cnt_clear, cnt_step, cnt_last, advance, load;
  logic [X_W-1:0]     dx_nxt;
  logic [Y_W-1:0]     dy_nxt;

  logic [X_W-1:0]     ev_x0, ev_w;
  logic [Y_W-1:0]     ev_y0, ev_h;
  logic [COLOR_W-1:0] ev_color;
  logic               ev_outline, ev_emit;
  logic [X_W:0]       ev_cx;
  logic [Y_W:0]       ev_cy;

  assign advance   = (state_q == DRAW) && (!plot_q || pix.pixel_ready);
  assign cnt_clear = (state_q == IDLE) && start;
  assign cnt_step  = advance && !cnt_last;

  rect_scan_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .clear_i  (cnt_clear),
    .step_i   (cnt_step),
    .w_i      (w_q),
    .h_i      (h_q),
    .dx_nxt_o (dx_nxt),
    .dy_nxt_o (dy_nxt),
    .last_o   (cnt_last)
  );

  // Evaluate the position being entered; in IDLE the request fields are not latched yet.
  always_comb begin
    if (state_q == IDLE) begin
      ev_x0      = x0;
      ev_y0      = y0;
      ev_w       = w;
      ev_h       = h;
      ev_color   = color;
      ev_outline = outline;
    end else begin
      ev_x0      = x0_q;
      ev_y0      = y0_q;
      ev_w       = w_q;
      ev_h       = h_q;
      ev_color   = color_q;
      ev_outline = outline_q;
    end
    ev_cx   = {1'b0, ev_x0} + {1'b0, dx_nxt};
    ev_cy   = {1'b0, ev_y0} + {1'b0, dy_nxt};
    ev_emit = (ev_cx < ScreenWX) && (ev_cy < ScreenHY) &&
              (!ev_outline || on_border(CoordW'(dx_nxt), CoordW'(dy_nxt),
                                        CoordW'(ev_w), CoordW'(ev_h)));
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    outline_d   = outline_q;
    plot_d      = plot_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        plot_d = 1'b0;
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          w_d       = w;
          h_d       = h;
          color_d   = color;
          outline_d = outline;
          if (w == '0 || h == '0) begin
            state_d = DONE;
          end else begin
            state_d = DRAW;
            load    = 1'b1;
          end
        end
      end
      DRAW: begin
        if (advance) begin
          if (cnt_last) begin
            state_d = DONE;
            plot_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: begin
        plot_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Skipped positions drop plot but leave the coordinate fields untouched.
    if (load) begin
      plot_d = ev_emit;
      if (ev_emit) begin
        vga_x_d     = ev_cx[X_W-1:0];
        vga_y_d     = ev_cy[Y_W-1:0];
        vga_color_d = ev_color;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      outline_q   <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      outline_q   <= outline_d;
      plot_q      <= plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
    end
  end

  assign pix.VGA_X     = vga_x_q;
  assign pix.VGA_Y     = vga_y_q;
  assign pix.VGA_COLOR = vga_color_q;
  assign pix.plot      = plot_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_rect_plotter.sv
// Directed-vector bench for rect_plotter: fill, outline, clipping, backpressure,
// degenerate sizes and asynchronous reset mid-draw.
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] color;
  logic       outline;
  logic       busy, done;

  int vec_count = 0;
  int err_count = 0;

  rect_plotter_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) pix ();

  rect_plotter #(
    .X_W      (8),
    .Y_W      (7),
    .COLOR_W  (3),
    .SCREEN_W (160),
    .SCREEN_H (120)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .outline  (outline),
    .pix      (pix),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Returns on the falling edge right after the start edge: first position is visible.
  task automatic do_start(input logic [7:0] sx, input logic [6:0] sy, input logic [7:0] sw,
                          input logic [6:0] sh, input logic [2:0] sc, input logic so);
    @(negedge CLOCK_50);
    x0 = sx; y0 = sy; w = sw; h = sh; color = sc; outline = so;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; color = '0; outline = 1'b0;
    pix.pixel_ready = 1'b1;
    @(negedge CLOCK_50);
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL reset_ctrl: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
    vec_count++;
    if ({pix.VGA_X, pix.VGA_Y, pix.VGA_COLOR} !== 18'h0) begin
      err_count++;
      $display("FAIL reset_fields: x=%0d y=%0d c=%0d expected 0 0 0",
               pix.VGA_X, pix.VGA_Y, pix.VGA_COLOR);
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL reset_idle: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
  endtask

  task automatic test_fill;
    int exs [6] = '{10, 11, 12, 10, 11, 12};
    int eys [6] = '{5, 5, 5, 6, 6, 6};
    do_start(8'd10, 7'd5, 8'd3, 7'd2, 3'b101, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vec_count++;
      if (pix.plot !== 1'b1 || pix.VGA_X !== 8'(exs[i]) || pix.VGA_Y !== 7'(eys[i]) ||
          pix.VGA_COLOR !== 3'b101 || busy !== 1'b1 || done !== 1'b0) begin
        err_count++;
        $display("FAIL fill_px%0d: got plot=%b (%0d,%0d) c=%b busy=%b done=%b, want plot=1 (%0d,%0d) c=101 busy=1 done=0",
                 i, pix.plot, pix.VGA_X, pix.VGA_Y, pix.VGA_COLOR, busy, done, exs[i], eys[i]);
      end
      @(negedge CLOCK_50);
    end
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b011) begin
      err_count++;
      $display("FAIL fill_done: plot/busy/done=%b expected 011", {pix.plot, busy, done});
    end
    @(negedge CLOCK_50);
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL fill_idle: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
  endtask

  task automatic test_outline;
    logic [15:0] mask = 16'b1111_1001_1001_1111;
    int cyc = 0, plots = 0, inner = 0;
    do_start(8'd0, 7'd0, 8'd4, 7'd4, 3'b010, 1'b1);
    for (int k = 0; k < 100; k++) begin
      if (done || !busy) break;
      if (cyc < 16) begin
        vec_count++;
        if (pix.plot !== mask[cyc]) begin
          err_count++;
          $display("FAIL outline_pos%0d: plot=%b expected %b", cyc, pix.plot, mask[cyc]);
        end
      end
      if (pix.plot) begin
        plots++;
        if ((pix.VGA_X == 8'd1 || pix.VGA_X == 8'd2) && (pix.VGA_Y == 7'd1 || pix.VGA_Y == 7'd2))
          inner++;
      end
      cyc++;
      @(negedge CLOCK_50);
    end
    vec_count++;
    if (done !== 1'b1) begin
      err_count++;
      $display("FAIL outline_done: done=%b expected 1 (cycle budget)", done);
    end
    vec_count++;
    if (cyc != 16 || plots != 12 || inner != 0) begin
      err_count++;
      $display("FAIL outline_counts: cycles=%0d plots=%0d interior=%0d expected 16 12 0",
               cyc, plots, inner);
    end
  endtask

  task automatic test_clip;
    int cyc = 0, plots = 0;
    logic [7:0] px [2];
    logic [6:0] py [2];
    px[0] = '0; px[1] = '0; py[0] = '0; py[1] = '0;
    do_start(8'd158, 7'd119, 8'd4, 7'd3, 3'b111, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (done || !busy) break;
      if (pix.plot) begin
        if (plots < 2) begin
          px[plots] = pix.VGA_X;
          py[plots] = pix.VGA_Y;
        end
        plots++;
      end
      cyc++;
      @(negedge CLOCK_50);
    end
    vec_count++;
    if (done !== 1'b1 || cyc != 12) begin
      err_count++;
      $display("FAIL clip_cycles: done=%b draw_cycles=%0d expected 1 12", done, cyc);
    end
    vec_count++;
    if (plots != 2) begin
      err_count++;
      $display("FAIL clip_plots: plots=%0d expected 2", plots);
    end
    vec_count++;
    if (px[0] !== 8'd158 || py[0] !== 7'd119 || px[1] !== 8'd159 || py[1] !== 7'd119) begin
      err_count++;
      $display("FAIL clip_coords: (%0d,%0d) (%0d,%0d) expected (158,119) (159,119)",
               px[0], py[0], px[1], py[1]);
    end
  endtask

  task automatic test_backpressure;
    int exs [6] = '{10, 11, 12, 10, 11, 12};
    int eys [6] = '{5, 5, 5, 6, 6, 6};
    int n = 0, hold = 0;
    bit fin = 0;
    pix.pixel_ready = 1'b1;
    do_start(8'd10, 7'd5, 8'd3, 7'd2, 3'b101, 1'b0);
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        fin = 1;
        break;
      end
      pix.pixel_ready = !(c >= 1 && c <= 3);
      if (pix.plot) begin
        if (pix.VGA_X == 8'd11 && pix.VGA_Y == 7'd5) hold++;
        if (pix.pixel_ready) begin
          vec_count++;
          if (n >= 6) begin
            err_count++;
            $display("FAIL bp_extra: accepted extra pixel (%0d,%0d) as #%0d, expected 6 total",
                     pix.VGA_X, pix.VGA_Y, n);
          end else if (pix.VGA_X !== 8'(exs[n]) || pix.VGA_Y !== 7'(eys[n]) ||
                       pix.VGA_COLOR !== 3'b101) begin
            err_count++;
            $display("FAIL bp_px%0d: got (%0d,%0d) c=%b expected (%0d,%0d) c=101",
                     n, pix.VGA_X, pix.VGA_Y, pix.VGA_COLOR, exs[n], eys[n]);
          end
          n++;
        end
      end
      @(negedge CLOCK_50);
    end
    pix.pixel_ready = 1'b1;
    vec_count++;
    if (fin != 1 || n != 6) begin
      err_count++;
      $display("FAIL bp_count: done_seen=%0d accepted=%0d expected 1 6", fin, n);
    end
    vec_count++;
    if (hold != 4) begin
      err_count++;
      $display("FAIL bp_hold: (11,5) shown for %0d cycles expected 4", hold);
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_degenerate;
    do_start(8'd5, 7'd5, 8'd0, 7'd7, 3'b001, 1'b0);
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b011) begin
      err_count++;
      $display("FAIL degen_done: plot/busy/done=%b expected 011", {pix.plot, busy, done});
    end
    // Request while still busy must be dropped, not queued.
    w = 8'd2; h = 7'd1;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL degen_ignore: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
    @(negedge CLOCK_50);
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL degen_idle: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
  endtask

  task automatic test_reset_mid;
    do_start(8'd20, 7'd30, 8'd4, 7'd2, 3'b111, 1'b0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    vec_count++;
    if (pix.plot !== 1'b1 || pix.VGA_X !== 8'd22 || pix.VGA_Y !== 7'd30) begin
      err_count++;
      $display("FAIL rst_pre: plot=%b (%0d,%0d) expected 1 (22,30)", pix.plot, pix.VGA_X, pix.VGA_Y);
    end
    #2 reset = 1'b1;
    #1;
    vec_count++;
    if ({pix.plot, busy, done} !== 3'b000) begin
      err_count++;
      $display("FAIL rst_async: plot/busy/done=%b expected 000", {pix.plot, busy, done});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    do_start(8'd20, 7'd30, 8'd4, 7'd2, 3'b110, 1'b0);
    vec_count++;
    if (pix.plot !== 1'b1 || pix.VGA_X !== 8'd20 || pix.VGA_Y !== 7'd30 || pix.VGA_COLOR !== 3'b110) begin
      err_count++;
      $display("FAIL rst_fresh0: plot=%b (%0d,%0d) c=%b expected 1 (20,30) c=110",
               pix.plot, pix.VGA_X, pix.VGA_Y, pix.VGA_COLOR);
    end
    @(negedge CLOCK_50);
    vec_count++;
    if (pix.plot !== 1'b1 || pix.VGA_X !== 8'd21 || pix.VGA_Y !== 7'd30) begin
      err_count++;
      $display("FAIL rst_fresh1: plot=%b (%0d,%0d) expected 1 (21,30)", pix.plot, pix.VGA_X, pix.VGA_Y);
    end
    for (int k = 0; k < 50; k++) begin
      if (done) break;
      @(negedge CLOCK_50);
    end
    vec_count++;
    if (done !== 1'b1) begin
      err_count++;
      $display("FAIL rst_fresh_done: done=%b expected 1 (cycle budget)", done);
    end
    @(negedge CLOCK_50);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_backpressure();
    test_degenerate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
